// File: rtl/accum_debounced.sv
// Pushbutton-stepped accumulator: synchroniser, debouncer, press-edge detector and clear/add/sub/load datapath.
// Define ACCUM_SATURATE_EN to clamp Sum on carry/borrow instead of wrapping.
module accum_debounced #(
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 10,
  parameter int CNT_W     = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Step,
  input  logic [1:0]        Mode,
  input  logic [DATA_W-1:0] Data,
  output logic [ACC_W-1:0]  Sum,
  output logic              Overflow,
  output logic [CNT_W-1:0]  Count,
  output logic              Done
);

  typedef enum logic [1:0] {
    OP_CLR  = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic           s1, s2, db, db_prev;
  logic [DBW-1:0] db_cnt;
  logic           op;

  // Front end: db only follows s2 after it has differed for DB_CYCLES edges.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      db      <= 1'b1;
      db_prev <= 1'b1;
      db_cnt  <= '0;
    end else begin
      s1      <= Step;
      s2      <= s1;
      db_prev <= db;
      if (s2 == db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db     <= s2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Press is the falling edge of the debounced (active-low) level.
  assign op = ~db & db_prev;

  logic [ACC_W:0]   ext, res;
  logic [ACC_W-1:0] sum_nxt;
  logic             ovf_nxt;

  assign ext = {{(ACC_W + 1 - DATA_W){1'b0}}, Data};

  always_comb begin
    sum_nxt = Sum;
    ovf_nxt = Overflow;
    res     = '0;
    case (op_e'(Mode))
      OP_CLR: begin
        sum_nxt = '0;
        ovf_nxt = 1'b0;
      end
      OP_ADD: begin
        res     = {1'b0, Sum} + ext;
        sum_nxt = res[ACC_W-1:0];
        if (res[ACC_W]) begin
          ovf_nxt = 1'b1;
`ifdef ACCUM_SATURATE_EN
          sum_nxt = '1;
`endif
        end
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow (ext > Sum).
        res     = {1'b0, Sum} - ext;
        sum_nxt = res[ACC_W-1:0];
        if (res[ACC_W]) begin
          ovf_nxt = 1'b1;
`ifdef ACCUM_SATURATE_EN
          sum_nxt = '0;
`endif
        end
      end
      OP_LOAD: begin
        sum_nxt = ext[ACC_W-1:0];
        ovf_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Sum      <= '0;
      Overflow <= 1'b0;
      Count    <= '0;
      Done     <= 1'b0;
    end else begin
      Done <= op;
      if (op) begin
        Sum      <= sum_nxt;
        Overflow <= ovf_nxt;
        Count    <= Count + 1'b1;
      end
    end
  end

endmodule
